// File: rtl/weight_stream_reader_if.sv
// Valid/ready word stream with a last tag. Signal names follow the producer's view.
interface weight_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  last_o;

    modport master (output valid_o, data_o, last_o, input ready_i);
    modport slave  (input valid_o, data_o, last_o, output ready_i);
endinterface

// File: rtl/weight_stream_reader.sv
// Reads DEPTH weights addressed by an external counter and streams them out through a 2-entry buffer.
// Optional macro WEIGHT_STREAM_READER_RANGE_CHECK_EN adds a sticky range_err_o flag.
module weight_stream_reader #(
    parameter int WORD_SIZE  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 10,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [WORD_SIZE-1:0]   index_i,
    output logic                   en_o,
    input  logic                   wr_en_i,
    input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    weight_stream_reader_if.master out_if,
    output logic                   busy_o,
    output logic                   done_o
`ifdef WEIGHT_STREAM_READER_RANGE_CHECK_EN
    ,
    output logic                   range_err_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]      LAST_ISSUE = CNT_W'(DEPTH - 1);
    localparam logic [WORD_SIZE:0]    IDX_LIMIT  = (WORD_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   WR_LIMIT   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [1:0]            fill_q, fill_d;
    logic                  wr_ptr_q, rd_ptr_q;
    logic                  vld_p1, last_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic       issue, issue_last, done, push, pop, space_ok, idx_ok, wr_ok, valid;
    logic [2:0] occ;

    assign idx_ok = {1'b0, index_i} < IDX_LIMIT;
    assign wr_ok  = {1'b0, wr_addr_i} < WR_LIMIT;

    assign valid = (fill_q != 2'd0);
    assign pop   = valid & out_if.ready_i;
    assign push  = vld_p1;

    // A word in flight from memory already owns a buffer slot.
    assign occ      = {1'b0, fill_q} + {2'b00, vld_p1};
    assign space_ok = occ < (3'd2 + {2'b00, pop});

    assign issue_last = (state_q == S_READ) && (issued_q == LAST_ISSUE);

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        issue    = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    issue    = space_ok;
                    issued_d = {{(CNT_W - 1){1'b0}}, space_ok};
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                issue = space_ok;
                if (space_ok) begin
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q == LAST_ISSUE) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && out_if.last_o) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        if (push && !pop)      fill_d = fill_q + 2'd1;
        else if (!push && pop) fill_d = fill_q - 2'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            fill_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            fill_q   <= fill_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            // p1: read issued last cycle, data now in rd_data_p1
            vld_p1   <= issue;
            last_p1  <= issue && issue_last;
        end
    end

    // Read-first: the read below sees the pre-write contents on an address collision.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && wr_ok) mem[wr_addr_i] <= wr_data_i;
        if (issue) rd_data_p1 <= idx_ok ? mem[index_i[ADDR_WIDTH-1:0]] : '0;
        // p2: buffered word awaiting handshake
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rd_data_p1;
            fifo_last_q[wr_ptr_q] <= last_p1;
        end
    end

    assign out_if.valid_o = valid;
    assign out_if.data_o  = valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_if.last_o  = valid & fifo_last_q[rd_ptr_q];
    assign en_o           = issue;
    assign done_o         = done;
    assign busy_o         = (state_q != S_IDLE);

`ifdef WEIGHT_STREAM_READER_RANGE_CHECK_EN
    logic range_err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            range_err_q <= 1'b0;
        end else if ((issue && !idx_ok) || (wr_en_i && !wr_ok)) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err_o = range_err_q;
`endif

endmodule

// File: tb/tb_weight_stream_reader.sv
// Bench for weight_stream_reader at DEPTH=4: word-level model predicts handshakes, a scoreboard checks data.
`timescale 1ns/1ps
module tb_weight_stream_reader;
    localparam int WORD_SIZE  = 16;
    localparam int DATA_WIDTH = 16;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  wr_en = 1'b0;
    logic [ADDR_WIDTH-1:0] wr_addr = '0;
    logic [DATA_WIDTH-1:0] wr_data = '0;
    logic [WORD_SIZE-1:0]  index, cnt;
    logic                  ovr_en = 1'b0;
    logic [WORD_SIZE-1:0]  ovr_val = 16'd5;
    logic                  en, busy, done;
`ifdef WEIGHT_STREAM_READER_RANGE_CHECK_EN
    logic                  range_err;
`endif

    int total = 0;
    int bad   = 0;

    weight_stream_reader_if #(.DATA_WIDTH(DATA_WIDTH)) sif();

    weight_stream_reader #(
        .WORD_SIZE(WORD_SIZE), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk_i(clk), .reset_i(rst), .start_i(start), .index_i(index), .en_o(en),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .out_if(sif), .busy_o(busy), .done_o(done)
`ifdef WEIGHT_STREAM_READER_RANGE_CHECK_EN
        , .range_err_o(range_err)
`endif
    );

    always #5 clk = ~clk;

    // Upstream enabled counter: advances on en, returns to 0 at the end of a pass.
    always @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (done) cnt <= '0;
        else if (en)   cnt <= cnt + 16'd1;
    end
    assign index = ovr_en ? ovr_val : cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [DATA_WIDTH-1:0] d; bit l; } exp_t;
    exp_t exp_q[$];

    logic [DATA_WIDTH-1:0] model_mem [DEPTH];
    int issues_total = 0, pops_total = 0, pass_issues = 0, pass_pops = 0;
    bit issued_last = 0, model_busy = 0, model_err = 0;

    // Model: words issued-but-not-accepted may never exceed two; a word is visible
    // one cycle after its read; a pass is DEPTH issues and ends on the DEPTH-th acceptance.
    always @(negedge clk) begin
        int outst;
        bit ev, pop, allowed, ee, ed;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            issues_total = 0; pops_total = 0; pass_issues = 0; pass_pops = 0;
            issued_last = 0; model_busy = 0; model_err = 0;
        end else begin
            outst   = issues_total - pops_total;
            ev      = (outst - int'(issued_last)) > 0;
            pop     = ev && sif.ready_i;
            allowed = model_busy ? (pass_issues < DEPTH) : start;
            ee      = allowed && ((outst - int'(pop)) < 2);
            ed      = pop && model_busy && (pass_pops == DEPTH - 1);
            check("valid_o", 32'(sif.valid_o), 32'(ev));
            check("en_o", 32'(en), 32'(ee));
            check("busy_o", 32'(busy), 32'(model_busy));
            check("done_o", 32'(done), 32'(ed));
`ifdef WEIGHT_STREAM_READER_RANGE_CHECK_EN
            check("range_err_o", 32'(range_err), 32'(model_err));
`endif
            if (!model_busy && start) begin
                pass_issues = 0;
                pass_pops   = 0;
            end
            if (en) begin
                e.d = (int'(index) < DEPTH) ? model_mem[index[ADDR_WIDTH-1:0]] : '0;
                pass_issues++;
                e.l = (pass_issues == DEPTH);
                exp_q.push_back(e);
                issues_total++;
                if (int'(index) >= DEPTH) model_err = 1;
            end
            issued_last = en;
            if (pop) begin
                pops_total++;
                pass_pops++;
            end
            if (wr_en && int'(wr_addr) < DEPTH) model_mem[wr_addr] = wr_data;
            if (ed) model_busy = 0;
            else if (!model_busy && start) model_busy = 1;
        end
    end

    // Scoreboard monitor: every accepted word is matched against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!rst && sif.valid_o && sif.ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: unexpected word %0h, expected none", sif.data_o);
            end else begin
                e = exp_q.pop_front();
                check("data_o", 32'(sif.data_o), 32'(e.d));
                check("last_o", 32'(sif.last_o), 32'(e.l));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        sif.ready_i = 1'b1;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready and random writes
    task automatic do_pass(input int mode, input int hold_start, input int wr_idx,
                           input logic [DATA_WIDTH-1:0] wr_val, input int ovr_idx, input string tag);
        bit wrote = 0;
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            case (mode)
                0:       sif.ready_i = 1'b1;
                1:       sif.ready_i = (k % 3 == 0);
                default: sif.ready_i = 1'($urandom_range(0, 1));
            endcase
            wr_en = 1'b0;
            if (wr_idx >= 0 && int'(cnt) == wr_idx && !wrote) begin
                wr_en = 1'b1; wr_addr = wr_idx[ADDR_WIDTH-1:0]; wr_data = wr_val; wrote = 1;
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                wr_en = 1'b1; wr_addr = ADDR_WIDTH'($urandom_range(0, DEPTH - 1)); wr_data = 16'($urandom);
            end
            ovr_en = (ovr_idx >= 0) && (int'(cnt) == ovr_idx);
            tick();
            if (k >= hold_start) start = 1'b0;
            if (!busy && !start) break;
        end
        wr_en  = 1'b0;
        ovr_en = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        sif.ready_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_o", 32'(sif.valid_o), 0);
        check("reset busy_o", 32'(busy), 0);
        check("reset done_o", 32'(done), 0);
        check("reset en_o", 32'(en), 0);
        check("reset data_o", 32'(sif.data_o), 0);
        check("reset last_o", 32'(sif.last_o), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_WIDTH'(i); wr_data = 16'(16'h100 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();

        do_pass(0, 0, -1, '0, -1, "pass_ready_high");
        do_pass(1, 0, -1, '0, -1, "pass_ready_toggle");
        do_pass(0, 0, 2, 16'hABCD, -1, "pass_write_collision");
        do_pass(0, 0, -1, '0, -1, "pass_after_write");
        do_pass(0, 8, -1, '0, -1, "pass_start_held");
        do_pass(2, 0, -1, '0, 1, "pass_out_of_range");
        for (int r = 0; r < 6; r++) do_pass(2, 0, -1, '0, -1, "pass_random");

        // Reset mid-pass with the buffer full and downstream stalled.
        start = 1'b1; sif.ready_i = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre-reset valid_o", 32'(sif.valid_o), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async reset valid_o", 32'(sif.valid_o), 0);
        check("async reset busy_o", 32'(busy), 0);
        check("async reset en_o", 32'(en), 0);
        check("async reset done_o", 32'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sif.ready_i = 1'b1;
        tick();

        do_pass(0, 0, -1, '0, -1, "pass_after_reset");
        do_pass(2, 0, -1, '0, -1, "pass_final_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
